// File: rtl/jtag_uart_responder_pkg.sv
// Shared constants and types for the JTAG UART register responder.
package jtag_uart_pkg;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam int RVALID_BIT = 15;
  localparam int TXDROP_BIT = 10;
  localparam int RAVAIL_LSB = 16;
  localparam int WSPACE_LSB = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

endpackage

// File: rtl/jtag_uart_responder_if.sv
// Avalon-MM slave bus plus host-side byte streams of the JTAG UART responder.
interface jtag_uart_if;
  logic        avalon_jtag_slave_chipselect;
  logic        avalon_jtag_slave_address;
  logic        avalon_jtag_slave_read_n;
  logic        avalon_jtag_slave_write_n;
  logic [31:0] avalon_jtag_slave_writedata;
  logic [31:0] avalon_jtag_slave_readdata;
  logic        avalon_jtag_slave_waitrequest;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport slave (
    input  avalon_jtag_slave_chipselect, avalon_jtag_slave_address,
           avalon_jtag_slave_read_n, avalon_jtag_slave_write_n,
           avalon_jtag_slave_writedata, rx_data, rx_valid, tx_ready,
    output avalon_jtag_slave_readdata, avalon_jtag_slave_waitrequest,
           rx_ready, tx_data, tx_valid
  );

  modport master (
    output avalon_jtag_slave_chipselect, avalon_jtag_slave_address,
           avalon_jtag_slave_read_n, avalon_jtag_slave_write_n,
           avalon_jtag_slave_writedata, rx_data, rx_valid, tx_ready,
    input  avalon_jtag_slave_readdata, avalon_jtag_slave_waitrequest,
           rx_ready, tx_data, tx_valid
  );
endinterface

// File: rtl/jtag_uart_responder_sync_byte_fifo.sv
// Single-clock byte FIFO with show-ahead head; push when full and pop when
// empty are ignored, so callers may present requests without pre-gating.
module sync_byte_fifo #(
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [7:0]    push_data,
  input  logic          pop,
  output logic [7:0]    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/jtag_uart_responder.sv
// JTAG UART register responder: Avalon-MM DATA/CONTROL registers bridged to
// host byte streams through an RX and a TX FIFO.
//
// state | meaning
// IDLE  | no read in progress; a new read stalls one cycle and is latched
// RESP  | readdata holds the latched word, master completes the transfer
module jtag_uart_responder
  import jtag_uart_pkg::*;
#(
  parameter int RX_DEPTH = 64,
  parameter int TX_DEPTH = 64
) (
  input logic         clk,
  input logic         reset,
  jtag_uart_if.slave  bus
);

  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  state_t state, state_nxt;
  logic   waitrequest;
  logic   latch_rd;
  logic   read_req;
  logic   write_acc;
  logic   tx_drop;
  logic [31:0] readdata;
  logic [31:0] rd_word;

  logic [7:0]       rx_head, tx_head;
  logic [RX_CW-1:0] rx_count;
  logic [TX_CW-1:0] tx_count;
  logic             rx_full, rx_empty, tx_full, tx_empty;
  logic             rx_pop, tx_push;
  logic [15:0]      ravail, wspace;
  logic             unused_wdata;

  // A read on the same cycle as a write wins; the write is discarded.
  assign read_req  = bus.avalon_jtag_slave_chipselect && !bus.avalon_jtag_slave_read_n;
  assign write_acc = bus.avalon_jtag_slave_chipselect && !bus.avalon_jtag_slave_write_n
                     && bus.avalon_jtag_slave_read_n;

  assign rx_pop  = latch_rd && (bus.avalon_jtag_slave_address == ADDR_DATA) && !rx_empty;
  assign tx_push = write_acc && (bus.avalon_jtag_slave_address == ADDR_DATA);

  assign ravail = 16'(rx_count) - 16'd1;
  assign wspace = 16'(TX_DEPTH) - 16'(tx_count);

  assign unused_wdata = ^{bus.avalon_jtag_slave_writedata[31:11],
                          bus.avalon_jtag_slave_writedata[9:8]};

  sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (bus.rx_valid),
    .push_data (bus.rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (tx_push),
    .push_data (bus.avalon_jtag_slave_writedata[7:0]),
    .pop       (bus.tx_ready),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  // Read FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a read in IDLE stalls once and latches; RESP always returns.
  always_comb begin
    state_nxt   = state;
    waitrequest = 1'b0;
    latch_rd    = 1'b0;
    case (state)
      IDLE: begin
        if (read_req) begin
          waitrequest = 1'b1;
          latch_rd    = 1'b1;
          state_nxt   = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Assemble the register word; RAVAIL reports the count left after this pop.
  always_comb begin
    rd_word = '0;
    if (bus.avalon_jtag_slave_address == ADDR_CTRL) begin
      rd_word[WSPACE_LSB +: 16] = wspace;
      rd_word[TXDROP_BIT]       = tx_drop;
    end else if (!rx_empty) begin
      rd_word[RAVAIL_LSB +: 16] = ravail;
      rd_word[RVALID_BIT]       = 1'b1;
      rd_word[7:0]              = rx_head;
    end
  end

  // Registered read data, captured on the stalling edge.
  always_ff @(posedge clk) begin
    if (reset)         readdata <= '0;
    else if (latch_rd) readdata <= rd_word;
  end

  // Sticky overflow flag: set on a dropped DATA write, cleared via CONTROL bit 10.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_drop <= 1'b0;
    end else if (write_acc) begin
      if (bus.avalon_jtag_slave_address == ADDR_DATA) begin
        if (tx_full) tx_drop <= 1'b1;
      end else if (bus.avalon_jtag_slave_writedata[TXDROP_BIT]) begin
        tx_drop <= 1'b0;
      end
    end
  end

  assign bus.avalon_jtag_slave_readdata    = readdata;
  assign bus.avalon_jtag_slave_waitrequest = waitrequest;
  assign bus.rx_ready = !rx_full;
  assign bus.tx_data  = tx_head;
  assign bus.tx_valid = !tx_empty;

endmodule
